// File: rtl/cmd_sched_pkg.sv
// -----------------------------------------------------------------------------
// cmd_sched_pkg
// Shared constants and types for the DRAM command-bus scheduler.
//   NUM_BANKS_DEF / PTR_WIDTH_DEF / CMD_WIDTH_DEF : default geometry
//   bank_idx_t  : bank index at the default pointer width
//   cmd_slot_t  : one output-register entry {valid, bank, cmd} at default widths
// -----------------------------------------------------------------------------
package cmd_sched_pkg;

  localparam int NUM_BANKS_DEF = 8;
  localparam int PTR_WIDTH_DEF = 3;
  localparam int CMD_WIDTH_DEF = 32;

  typedef logic [PTR_WIDTH_DEF-1:0] bank_idx_t;

  typedef struct packed {
    logic                     valid;
    bank_idx_t                bank;
    logic [CMD_WIDTH_DEF-1:0] cmd;
  } cmd_slot_t;

endpackage

// File: rtl/cmd_sched_starve_ctr.sv
// -----------------------------------------------------------------------------
// cmd_sched_starve_ctr
// Per-bank saturating wait counters and the resulting urgent vector. Used by
// cmd_bus_scheduler only when CMD_SCHED_STARVE_EN is defined.
//   i_clk       : clock, rising edge
//   i_rst       : synchronous active-high reset, clears all counters
//   i_req_valid : per-bank command pending
//   i_grant     : per-bank grant issued this cycle (one-hot or zero)
//   o_urgent    : per-bank wait count has reached LIMIT
// -----------------------------------------------------------------------------
module cmd_sched_starve_ctr
  import cmd_sched_pkg::*;
#(
  parameter int NUM_BANKS = NUM_BANKS_DEF,
  parameter int CNT_WIDTH = 4,
  parameter int LIMIT     = 12
) (
  input  logic                 i_clk,
  input  logic                 i_rst,
  input  logic [NUM_BANKS-1:0] i_req_valid,
  input  logic [NUM_BANKS-1:0] i_grant,
  output logic [NUM_BANKS-1:0] o_urgent
);

  logic [CNT_WIDTH-1:0] r_wait [NUM_BANKS];

  // NOTE: this counter array is cleared on reset on purpose; a stale count
  // would make a bank urgent right after reset and skew arbitration.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      for (int b = 0; b < NUM_BANKS; b++) r_wait[b] <= '0;
    end else begin
      for (int b = 0; b < NUM_BANKS; b++) begin
        if (!i_req_valid[b] || i_grant[b]) begin
          r_wait[b] <= '0;
        end else if (r_wait[b] != '1) begin
          r_wait[b] <= r_wait[b] + 1'b1;
        end
      end
    end
  end

  always_comb begin
    for (int b = 0; b < NUM_BANKS; b++) begin
      o_urgent[b] = (r_wait[b] >= CNT_WIDTH'(LIMIT));
    end
  end

endmodule

// File: rtl/cmd_bus_scheduler.sv
// -----------------------------------------------------------------------------
// cmd_bus_scheduler
// Round-robin scheduler sharing the single DRAM command bus among per-bank
// command queues. One winner per cycle, scanning from a rotating pointer, is
// captured into a one-entry output register that drives the command bus.
// Optional macro CMD_SCHED_STARVE_EN adds per-bank wait counters; banks that
// have waited STARVE_LIMIT cycles are arbitrated ahead of the others.
//   i_clk         : clock, rising edge
//   i_rst         : synchronous active-high reset (drops any held command)
//   i_req_valid   : per-bank command pending
//   i_req_cmd     : bank b payload at [b*CMD_WIDTH +: CMD_WIDTH]
//   o_req_ready   : one-hot (or zero) grant; consumes the granted bank's command
//   i_bus_blocked : timing stall, suppresses new grants only
//   o_cmd_valid   : output register holds a command
//   o_cmd         : granted payload
//   o_cmd_bank    : bank index of o_cmd
//   i_cmd_ready   : downstream accepts o_cmd this cycle
// -----------------------------------------------------------------------------
module cmd_bus_scheduler
  import cmd_sched_pkg::*;
#(
  parameter int NUM_BANKS        = NUM_BANKS_DEF,
  parameter int PTR_WIDTH        = PTR_WIDTH_DEF,
  parameter int CMD_WIDTH        = CMD_WIDTH_DEF,
  parameter int STARVE_CNT_WIDTH = 4,
  parameter int STARVE_LIMIT     = 12
) (
  input  logic                           i_clk,
  input  logic                           i_rst,
  input  logic [NUM_BANKS-1:0]           i_req_valid,
  input  logic [NUM_BANKS*CMD_WIDTH-1:0] i_req_cmd,
  output logic [NUM_BANKS-1:0]           o_req_ready,
  input  logic                           i_bus_blocked,
  output logic                           o_cmd_valid,
  output logic [CMD_WIDTH-1:0]           o_cmd,
  output logic [PTR_WIDTH-1:0]           o_cmd_bank,
  input  logic                           i_cmd_ready
);

  // Parameter sanity: the pointer relies on natural overflow to wrap.
  if (NUM_BANKS != (1 << PTR_WIDTH)) begin : g_bad_geometry
    $error("cmd_bus_scheduler: NUM_BANKS must equal 2**PTR_WIDTH");
  end
  if (STARVE_LIMIT >= (1 << STARVE_CNT_WIDTH)) begin : g_bad_starve_limit
    $error("cmd_bus_scheduler: STARVE_LIMIT must be < 2**STARVE_CNT_WIDTH");
  end

  typedef struct packed {
    logic                 valid;
    logic [PTR_WIDTH-1:0] bank;
    logic [CMD_WIDTH-1:0] cmd;
  } slot_t;

  slot_t                r_slot;
  logic [PTR_WIDTH-1:0] r_rr_ptr;

  logic [NUM_BANKS-1:0] w_cand;
  logic                 w_found;
  logic [PTR_WIDTH-1:0] w_win;
  logic                 w_can_load;
  logic                 w_load;
  logic [CMD_WIDTH-1:0] w_win_cmd;

`ifdef CMD_SCHED_STARVE_EN
  logic [NUM_BANKS-1:0] w_urgent;
  logic [NUM_BANKS-1:0] w_urgent_valid;

  cmd_sched_starve_ctr #(
    .NUM_BANKS (NUM_BANKS),
    .CNT_WIDTH (STARVE_CNT_WIDTH),
    .LIMIT     (STARVE_LIMIT)
  ) u_starve_ctr (
    .i_clk       (i_clk),
    .i_rst       (i_rst),
    .i_req_valid (i_req_valid),
    .i_grant     (o_req_ready),
    .o_urgent    (w_urgent)
  );

  // Urgent banks, when any are pending, restrict the candidate set; the
  // round-robin scan below is unchanged.
  assign w_urgent_valid = i_req_valid & w_urgent;
  assign w_cand         = (|w_urgent_valid) ? w_urgent_valid : i_req_valid;
`else
  assign w_cand = i_req_valid;
`endif

  // First candidate at or after the pointer, modulo NUM_BANKS.
  // NOTE: every variable driven here gets a default before the loop, so no
  // path leaves it unassigned and no latch is inferred.
  always_comb begin
    w_found = 1'b0;
    w_win   = '0;
    for (int i = 0; i < NUM_BANKS; i++) begin
      if (!w_found && w_cand[r_rr_ptr + PTR_WIDTH'(i)]) begin
        w_found = 1'b1;
        w_win   = r_rr_ptr + PTR_WIDTH'(i);
      end
    end
  end

  // Blocking only gates new grants; the held command can still drain.
  assign w_can_load  = !i_rst && !i_bus_blocked && (!r_slot.valid || i_cmd_ready);
  assign w_load      = w_can_load && w_found;
  assign o_req_ready = w_load ? (NUM_BANKS'(1) << w_win) : '0;
  assign w_win_cmd   = i_req_cmd[int'(w_win)*CMD_WIDTH +: CMD_WIDTH];

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values regardless of statement order.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_slot   <= '0;
      r_rr_ptr <= '0;
    end else if (w_load) begin
      // Covers simultaneous drain + load: the old entry is overwritten.
      r_slot   <= '{valid: 1'b1, bank: w_win, cmd: w_win_cmd};
      r_rr_ptr <= w_win + 1'b1;
    end else if (i_cmd_ready) begin
      r_slot.valid <= 1'b0;
    end
  end

  assign o_cmd_valid = r_slot.valid;
  assign o_cmd       = r_slot.cmd;
  assign o_cmd_bank  = r_slot.bank;

endmodule

// File: tb/tb_cmd_bus_scheduler.sv
// -----------------------------------------------------------------------------
// tb_cmd_bus_scheduler
// Self-checking bench for cmd_bus_scheduler. A small reference model tracks the
// round-robin pointer and output occupancy; each granted command is pushed to a
// scoreboard queue and compared when it is presented on the command bus.
// -----------------------------------------------------------------------------
module tb_cmd_bus_scheduler;
  import cmd_sched_pkg::*;

  localparam int NB = 8;
  localparam int PW = 3;
  localparam int CW = 32;

  logic              clk;
  logic              i_rst;
  logic [NB-1:0]     i_req_valid;
  logic [NB*CW-1:0]  i_req_cmd;
  logic [NB-1:0]     o_req_ready;
  logic              i_bus_blocked;
  logic              o_cmd_valid;
  logic [CW-1:0]     o_cmd;
  logic [PW-1:0]     o_cmd_bank;
  logic              i_cmd_ready;

  cmd_bus_scheduler #(
    .NUM_BANKS        (NB),
    .PTR_WIDTH        (PW),
    .CMD_WIDTH        (CW),
    .STARVE_CNT_WIDTH (4),
    .STARVE_LIMIT     (12)
  ) dut (
    .i_clk         (clk),
    .i_rst         (i_rst),
    .i_req_valid   (i_req_valid),
    .i_req_cmd     (i_req_cmd),
    .o_req_ready   (o_req_ready),
    .i_bus_blocked (i_bus_blocked),
    .o_cmd_valid   (o_cmd_valid),
    .o_cmd         (o_cmd),
    .o_cmd_bank    (o_cmd_bank),
    .i_cmd_ready   (i_cmd_ready)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;

  // Reference model state
  cmd_slot_t     sb_q[$];
  logic [PW-1:0] m_ptr;
  logic          m_valid;
  logic          m_zero;     // output payload/bank expected to read as zero
  logic [3:0]    m_wait [NB];

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%0h exp=%0h at %0t", tag, got, exp, $time);
    end
  endtask

  // One clock cycle: drive at negedge, check 1ns later, update model, advance.
  task automatic step(input logic [NB-1:0] vld, input logic rdy,
                      input logic blk, input logic rst);
    logic [NB-1:0] cand;
    logic [NB-1:0] exp_gnt;
    logic [NB-1:0] urg;
    logic          found;
    logic [PW-1:0] w;
    logic [PW-1:0] idx;
    cmd_slot_t     s;
    logic [CW-1:0] pay;

    i_req_valid   = vld;
    i_cmd_ready   = rdy;
    i_bus_blocked = blk;
    i_rst         = rst;
    for (int b = 0; b < NB; b++) i_req_cmd[b*CW +: CW] = $urandom;
    #1;

    cand = vld;
    urg  = '0;
`ifdef CMD_SCHED_STARVE_EN
    for (int b = 0; b < NB; b++) urg[b] = (m_wait[b] >= 4'd12);
    if (|(vld & urg)) cand = vld & urg;
`endif
    found   = 1'b0;
    w       = '0;
    exp_gnt = '0;
    if (!rst && !blk && (!m_valid || rdy)) begin
      for (int i = 0; i < NB; i++) begin
        idx = m_ptr + PW'(i);
        if (!found && cand[idx]) begin
          found = 1'b1;
          w     = idx;
        end
      end
    end
    if (found) exp_gnt[w] = 1'b1;

    check("req_ready", 64'(o_req_ready), 64'(exp_gnt));
    check("cmd_valid", 64'(o_cmd_valid), 64'(m_valid));
    if (m_valid) begin
      if (sb_q.size() == 0) begin
        check("sb_depth", 64'(sb_q.size()), 64'd1);
      end else begin
        check("cmd_payload", 64'(o_cmd), 64'(sb_q[0].cmd));
        check("cmd_bank", 64'(o_cmd_bank), 64'(sb_q[0].bank));
      end
    end
    if (m_zero) begin
      check("reset_cmd", 64'(o_cmd), 64'd0);
      check("reset_bank", 64'(o_cmd_bank), 64'd0);
    end

    if (rst) begin
      sb_q.delete();
      m_valid = 1'b0;
      m_ptr   = '0;
      m_zero  = 1'b1;
      for (int b = 0; b < NB; b++) m_wait[b] = '0;
    end else begin
      if (m_valid && rdy) void'(sb_q.pop_front());
      if (found) begin
        pay     = i_req_cmd[int'(w)*CW +: CW];
        s       = '{valid: 1'b1, bank: w, cmd: pay};
        sb_q.push_back(s);
        m_valid = 1'b1;
        m_ptr   = w + 1'b1;
        m_zero  = 1'b0;
      end else if (rdy) begin
        m_valid = 1'b0;
      end
      for (int b = 0; b < NB; b++) begin
        if (!vld[b] || exp_gnt[b]) m_wait[b] = '0;
        else if (m_wait[b] != 4'hF) m_wait[b] = m_wait[b] + 1'b1;
      end
    end

    @(posedge clk);
    @(negedge clk);
  endtask

  initial begin
    i_rst         = 1'b1;
    i_req_valid   = '1;
    i_req_cmd     = '0;
    i_bus_blocked = 1'b0;
    i_cmd_ready   = 1'b1;
    m_ptr         = '0;
    m_valid       = 1'b0;
    m_zero        = 1'b1;
    for (int b = 0; b < NB; b++) m_wait[b] = '0;
    @(posedge clk);
    @(negedge clk);

    // Reset held with all banks requesting: no grants, outputs zero.
    repeat (3) step(8'hFF, 1'b1, 1'b0, 1'b1);
    // Release: grants 0,1,...,7,0 back to back.
    repeat (9) step(8'hFF, 1'b1, 1'b0, 1'b0);

    // Move pointer to 6 via a lone bank-5 request, then wrap between 6 and 0.
    step(8'b0010_0000, 1'b1, 1'b0, 1'b0);
    repeat (3) step(8'b0100_0001, 1'b1, 1'b0, 1'b0);

    // Downstream stall: output held stable, no grants; then drain + load.
    repeat (3) step(8'hFF, 1'b0, 1'b0, 1'b0);
    repeat (2) step(8'hFF, 1'b1, 1'b0, 1'b0);

    // Bus blocked: no grants, pointer held, held command still drains.
    repeat (3) step(8'hFF, 1'b1, 1'b1, 1'b0);
    repeat (2) step(8'hFF, 1'b1, 1'b0, 1'b0);

    // Reset while a command is held: dropped, pointer back to 0.
    step(8'hFF, 1'b0, 1'b0, 1'b1);
    repeat (2) step(8'hFF, 1'b1, 1'b0, 1'b0);

`ifdef CMD_SCHED_STARVE_EN
    // Bank 3 waits longer than bank 2 behind a stalled output; pointer at 2.
    step(8'h00, 1'b1, 1'b0, 1'b1);
    step(8'b0000_0010, 1'b1, 1'b0, 1'b0);
    repeat (4) step(8'b0000_1000, 1'b0, 1'b0, 1'b0);
    repeat (8) step(8'b0000_1100, 1'b0, 1'b0, 1'b0);
    repeat (3) step(8'b0000_1100, 1'b1, 1'b0, 1'b0);
`endif

    // Randomised traffic.
    for (int n = 0; n < 300; n++) begin
      step(NB'($urandom) & NB'($urandom),
           ($urandom_range(3, 0) != 0),
           ($urandom_range(3, 0) == 0),
           ($urandom_range(49, 0) == 0));
    end

    // Drain and confirm nothing is left outstanding.
    repeat (2) step(8'h00, 1'b1, 1'b0, 1'b0);
    check("sb_final", 64'(sb_q.size()), 64'd0);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/cmd_bus_scheduler.md
# cmd_bus_scheduler

Sequential round-robin scheduler that shares the single DRAM command bus between per-bank command queues. Each cycle it selects one ready bank command, starting from a registered rotating pointer, and captures it into a one-entry output register that drives the command bus. It sits between the bank-queue array and the PHY command path in the command scheduler.

## Interface
- NUM_BANKS, 8, number of requesting banks; must equal 2**PTR_WIDTH
- PTR_WIDTH, 3, width of bank index and round-robin pointer
- CMD_WIDTH, 32, opaque command payload width
- STARVE_CNT_WIDTH, 4, width of per-bank wait counters (used only with CMD_SCHED_STARVE_EN)
- STARVE_LIMIT, 12, wait count at which a bank becomes urgent; must be < 2**STARVE_CNT_WIDTH
- i_clk  in  1  clock; all state updates on rising edge
- i_rst  in  1  synchronous, active-high reset
- i_req_valid  in  NUM_BANKS  per-bank command pending
- i_req_cmd  in  NUM_BANKS*CMD_WIDTH  bank b payload at bits [b*CMD_WIDTH +: CMD_WIDTH]
- o_req_ready  out  NUM_BANKS  one-hot (or zero) grant; bank b's command is consumed when i_req_valid[b] & o_req_ready[b]
- i_bus_blocked  in  1  timing stall from the timing checker (e.g. tCCD/tRRD); suppresses new grants
- o_cmd_valid  out  1  output register holds a command
- o_cmd  out  CMD_WIDTH  granted payload
- o_cmd_bank  out  PTR_WIDTH  bank index of o_cmd
- i_cmd_ready  in  1  downstream accepts o_cmd this cycle

## Operation
- State: rr_ptr (PTR_WIDTH), output register {valid, cmd, bank}.
- can_load = !i_bus_blocked & (!o_cmd_valid | i_cmd_ready).
- Arbitration (combinational): candidates = i_req_valid. Winner w = first set index scanning rr_ptr, rr_ptr+1, … mod NUM_BANKS.
- If can_load and any candidate: o_req_ready = onehot(w); on the edge, the output register loads {1, cmd[w], w} and rr_ptr <= w+1 (wraps NUM_BANKS-1 → 0 via natural PTR_WIDTH overflow).
- Otherwise o_req_ready = 0 and rr_ptr holds. If o_cmd_valid & i_cmd_ready and no new load, valid <= 0.
- o_req_ready never depends on i_req_valid of the same bank beyond winner selection; no grant is issued to a non-valid bank.
- o_cmd/o_cmd_bank remain stable while o_cmd_valid & !i_cmd_ready.
- i_bus_blocked does not affect a command already in the output register; it may still drain.

## Timing
- Reset: o_cmd_valid=0, o_cmd=0, o_cmd_bank=0, o_req_ready=0, rr_ptr=0, wait counters=0. Reset takes priority over every other event in the same cycle; an in-flight output command is dropped.
- Latency: request granted in cycle N → o_cmd_valid=1 in cycle N+1.
- Throughput: one command per cycle with i_cmd_ready held high and i_bus_blocked low.
- Simultaneous drain and load: the old command leaves and the new one is captured on the same edge; no bubble.
- Single requester: granted every eligible cycle; rr_ptr tracks (w+1).

## Configuration
- CMD_SCHED_STARVE_EN defined: per-bank saturating counter wait[b]. It increments each cycle i_req_valid[b] & !o_req_ready[b], clears on grant or when !i_req_valid[b], and saturates at all-ones. urgent[b] = wait[b] >= STARVE_LIMIT. If any urgent bank is valid, candidates = i_req_valid & urgent; otherwise candidates = i_req_valid. The same rr_ptr scan applies to either set.
- Not defined: counters and urgent logic are absent; pure round-robin.

## Structure
- Package cmd_sched_pkg holds: default NUM_BANKS/PTR_WIDTH/CMD_WIDTH constants, bank_idx_t typedef, and a cmd_slot_t struct {valid, bank, cmd}.
- One sub-module, cmd_sched_starve_ctr: the per-bank wait counter array plus urgent vector, instantiated only under CMD_SCHED_STARVE_EN.

## Test plan
- Reset with i_req_valid=8'hFF held high → all outputs 0 during reset; first grant after release goes to bank 0, then 1, 2, … 7, 0 with i_cmd_ready=1.
- rr_ptr=6, i_req_valid=8'b0100_0001 → grant bank 6, then bank 0 (wrap), then bank 6.
- o_cmd_valid=1, i_cmd_ready=0 for 3 cycles → o_req_ready=0 and o_cmd stable; raise i_cmd_ready → drain and new load on the same edge.
- i_bus_blocked=1 with requests pending → no grants and rr_ptr unchanged; the existing output still drains when i_cmd_ready=1.
- Assert i_rst while o_cmd_valid=1 → next cycle o_cmd_valid=0 and rr_ptr=0.
- With CMD_SCHED_STARVE_EN and STARVE_LIMIT=12: hold bank 3 valid while downstream stalls for 12 cycles with bank 2 also valid and rr_ptr=2 → bank 3 is granted before bank 2 once urgent.
